// File: rtl/reservation_station_pkg.sv
// Shared widths and wakeup-source encoding for the reservation station slice.
package reservation_station_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int TAG_W_DEF   = 6;
  localparam int OP_W_DEF    = 4;
  localparam int ENT_NUM_DEF = 2;

  typedef enum logic [1:0] {
    WK_NONE = 2'd0,
    WK_CDB0 = 2'd1,
    WK_CDB1 = 2'd2
  } wake_sel_e;

  // cdb0 wins when both buses hit the same waiting source
  function automatic wake_sel_e wake_pick(input logic hit0, input logic hit1);
    wake_sel_e sel;
    if (hit0) begin
      sel = WK_CDB0;
    end else if (hit1) begin
      sel = WK_CDB1;
    end else begin
      sel = WK_NONE;
    end
    return sel;
  endfunction

endpackage

// File: rtl/reservation_station_if.sv
// Dispatch, CDB broadcast and issue signals of the reservation station.
interface reservation_station_if
  import reservation_station_pkg::*;
#(
  parameter int ENT_NUM = ENT_NUM_DEF,
  parameter int ENT_SEL = $clog2(ENT_NUM),
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TAG_W   = TAG_W_DEF,
  parameter int OP_W    = OP_W_DEF
) ();

  logic               i_flush;
  logic               i_disp_vld;
  logic               o_disp_rdy;
  logic [OP_W-1:0]    i_disp_op;
  logic [TAG_W-1:0]   i_disp_rob_tag;
  logic               i_disp_src1_rdy;
  logic               i_disp_src2_rdy;
  logic [DATA_W-1:0]  i_disp_src1;
  logic [DATA_W-1:0]  i_disp_src2;
  logic               i_cdb0_vld;
  logic [TAG_W-1:0]   i_cdb0_tag;
  logic [DATA_W-1:0]  i_cdb0_data;
  logic               i_cdb1_vld;
  logic [TAG_W-1:0]   i_cdb1_tag;
  logic [DATA_W-1:0]  i_cdb1_data;
  logic [ENT_NUM-1:0] o_rdy_vec;
  logic               i_issue_vld;
  logic [ENT_SEL-1:0] i_issue_sel;
  logic [OP_W-1:0]    o_issue_op;
  logic [DATA_W-1:0]  o_issue_src1;
  logic [DATA_W-1:0]  o_issue_src2;
  logic [TAG_W-1:0]   o_issue_rob_tag;

  modport slave (
    input  i_flush, i_disp_vld, i_disp_op, i_disp_rob_tag,
    input  i_disp_src1_rdy, i_disp_src2_rdy, i_disp_src1, i_disp_src2,
    input  i_cdb0_vld, i_cdb0_tag, i_cdb0_data, i_cdb1_vld, i_cdb1_tag, i_cdb1_data,
    input  i_issue_vld, i_issue_sel,
    output o_disp_rdy, o_rdy_vec, o_issue_op, o_issue_src1, o_issue_src2, o_issue_rob_tag
  );

  modport master (
    output i_flush, i_disp_vld, i_disp_op, i_disp_rob_tag,
    output i_disp_src1_rdy, i_disp_src2_rdy, i_disp_src1, i_disp_src2,
    output i_cdb0_vld, i_cdb0_tag, i_cdb0_data, i_cdb1_vld, i_cdb1_tag, i_cdb1_data,
    output i_issue_vld, i_issue_sel,
    input  o_disp_rdy, o_rdy_vec, o_issue_op, o_issue_src1, o_issue_src2, o_issue_rob_tag
  );

  modport mon (
    input i_flush, i_disp_vld, i_disp_op, i_disp_rob_tag,
    input i_disp_src1_rdy, i_disp_src2_rdy, i_disp_src1, i_disp_src2,
    input i_cdb0_vld, i_cdb0_tag, i_cdb0_data, i_cdb1_vld, i_cdb1_tag, i_cdb1_data,
    input i_issue_vld, i_issue_sel,
    input o_disp_rdy, o_rdy_vec, o_issue_op, o_issue_src1, o_issue_src2, o_issue_rob_tag
  );

endinterface

// File: rtl/reservation_station_arb.sv
// Fixed-priority request arbiter: grants the lowest-index requester.
module req_arbiter #(
  parameter int N = 2
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt,
  output logic         gnt_vld
);

  // two's-complement trick isolates the lowest set bit
  assign gnt     = req & (~req + {{(N-1){1'b0}}, 1'b1});
  assign gnt_vld = |req;

endmodule

// File: rtl/reservation_station_chk.sv
// Protocol checks for the reservation station: illegal CDB and issue usage.
module reservation_station_chk (
  input logic                 i_clk,
  input logic                 i_rst_n,
  reservation_station_if.mon  bus
);

  // a tag can only be produced once, so both buses never carry the same tag
  a_cdb_dup_tag: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(bus.i_cdb0_vld && bus.i_cdb1_vld && (bus.i_cdb0_tag == bus.i_cdb1_tag)));

  a_issue_ready: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (bus.i_issue_vld && !bus.i_flush) |-> bus.o_rdy_vec[bus.i_issue_sel]);

endmodule

// File: rtl/reservation_station.sv
// Reservation station: holds dispatched ops until both operands are woken by the CDBs.
module reservation_station
  import reservation_station_pkg::*;
#(
  parameter int ENT_NUM = ENT_NUM_DEF,
  parameter int ENT_SEL = $clog2(ENT_NUM),
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TAG_W   = TAG_W_DEF,
  parameter int OP_W    = OP_W_DEF
) (
  input logic                  i_clk,
  input logic                  i_rst_n,
  reservation_station_if.slave bus
);

  logic [ENT_NUM-1:0] busy_r;
  logic [1:0]         src_rdy_r [ENT_NUM];
  logic [DATA_W-1:0]  src_val_r [ENT_NUM][2];
  logic [OP_W-1:0]    op_r      [ENT_NUM];
  logic [TAG_W-1:0]   rob_r     [ENT_NUM];

  logic [ENT_NUM-1:0] gnt_s;
  logic [ENT_NUM-1:0] rdy_s;
  logic               free_vld_s;
  logic               disp_fire_s;
  logic [ENT_SEL-1:0] sel_s;
  logic [DATA_W-1:0]  disp_raw_s [2];
  logic [1:0]         disp_raw_rdy_s;
  logic [DATA_W-1:0]  disp_val_s [2];
  logic [1:0]         disp_rdy_s;
  wake_sel_e          disp_wk_s  [2];
  wake_sel_e          ent_wk_s   [ENT_NUM][2];

  req_arbiter #(.N(ENT_NUM)) u_alloc (
    .req     (~busy_r),
    .gnt     (gnt_s),
    .gnt_vld (free_vld_s)
  );

  assign bus.o_disp_rdy = free_vld_s;
  assign disp_fire_s    = bus.i_disp_vld && free_vld_s && !bus.i_flush;
  assign sel_s          = bus.i_issue_sel;

  assign bus.o_issue_op      = op_r[sel_s];
  assign bus.o_issue_rob_tag = rob_r[sel_s];
  assign bus.o_issue_src1    = src_val_r[sel_s][0];
  assign bus.o_issue_src2    = src_val_r[sel_s][1];
  assign bus.o_rdy_vec       = rdy_s;

  // Resolve dispatched sources, catching a result broadcast in the same cycle
  always_comb begin
    disp_raw_s[0]  = bus.i_disp_src1;
    disp_raw_s[1]  = bus.i_disp_src2;
    disp_raw_rdy_s = {bus.i_disp_src2_rdy, bus.i_disp_src1_rdy};
    for (int s = 0; s < 2; s++) begin
      disp_wk_s[s]  = wake_pick(bus.i_cdb0_vld && (bus.i_cdb0_tag == disp_raw_s[s][TAG_W-1:0]),
                                bus.i_cdb1_vld && (bus.i_cdb1_tag == disp_raw_s[s][TAG_W-1:0]));
      disp_rdy_s[s] = 1'b1;
      disp_val_s[s] = disp_raw_s[s];
      if (disp_raw_rdy_s[s]) begin
        disp_val_s[s] = disp_raw_s[s];
      end else begin
        case (disp_wk_s[s])
          WK_CDB0: disp_val_s[s] = bus.i_cdb0_data;
          WK_CDB1: disp_val_s[s] = bus.i_cdb1_data;
          default: disp_rdy_s[s] = 1'b0;
        endcase
      end
    end
  end

  // Per-entry tag match against both broadcast buses, plus the issue-ready vector
  always_comb begin
    for (int i = 0; i < ENT_NUM; i++) begin
      rdy_s[i] = busy_r[i] & src_rdy_r[i][0] & src_rdy_r[i][1];
      for (int s = 0; s < 2; s++) begin
        ent_wk_s[i][s] = wake_pick(
          busy_r[i] && !src_rdy_r[i][s] && bus.i_cdb0_vld &&
            (bus.i_cdb0_tag == src_val_r[i][s][TAG_W-1:0]),
          busy_r[i] && !src_rdy_r[i][s] && bus.i_cdb1_vld &&
            (bus.i_cdb1_tag == src_val_r[i][s][TAG_W-1:0]));
      end
    end
  end

  // Entry state: reset and flush drop every entry; payload fields are left as-is
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || bus.i_flush) begin
      busy_r <= '0;
      for (int i = 0; i < ENT_NUM; i++) begin
        src_rdy_r[i] <= 2'b00;
      end
    end else begin
      for (int i = 0; i < ENT_NUM; i++) begin
        if (disp_fire_s && gnt_s[i]) begin
          busy_r[i]       <= 1'b1;
          op_r[i]         <= bus.i_disp_op;
          rob_r[i]        <= bus.i_disp_rob_tag;
          src_rdy_r[i]    <= disp_rdy_s;
          src_val_r[i][0] <= disp_val_s[0];
          src_val_r[i][1] <= disp_val_s[1];
        end else begin
          // an issued entry is freed even if it was not ready
          if (bus.i_issue_vld && (sel_s == ENT_SEL'(i))) begin
            busy_r[i] <= 1'b0;
          end
          for (int s = 0; s < 2; s++) begin
            case (ent_wk_s[i][s])
              WK_CDB0: begin
                src_rdy_r[i][s] <= 1'b1;
                src_val_r[i][s] <= bus.i_cdb0_data;
              end
              WK_CDB1: begin
                src_rdy_r[i][s] <= 1'b1;
                src_val_r[i][s] <= bus.i_cdb1_data;
              end
              default: begin
                src_rdy_r[i][s] <= src_rdy_r[i][s];
              end
            endcase
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
// Directed, table-driven bench for the two-entry reservation station.
module tb_reservation_station;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  reservation_station_if #(.ENT_NUM(2), .ENT_SEL(1), .DATA_W(32), .TAG_W(6), .OP_W(4)) bus ();

  reservation_station #(.ENT_NUM(2), .ENT_SEL(1), .DATA_W(32), .TAG_W(6), .OP_W(4)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  reservation_station_chk u_chk (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        dv;
    logic [3:0]  op;
    logic [5:0]  tag;
    logic        r1;
    logic [31:0] s1;
    logic        r2;
    logic [31:0] s2;
    logic        c0v;
    logic [5:0]  c0t;
    logic [31:0] c0d;
    logic        c1v;
    logic [5:0]  c1t;
    logic [31:0] c1d;
    logic        iv;
    logic        isel;
    logic        fl;
    logic        e_dr;
    logic [1:0]  e_rv;
    logic        e_chk;
    logic [3:0]  e_op;
    logic [5:0]  e_tag;
    logic [31:0] e_s1;
    logic [31:0] e_s2;
  } vec_t;

  vec_t vq[$];
  vec_t cur;

  task automatic nv();
    cur = '0;
  endtask

  task automatic d(input logic [3:0] op, input logic [5:0] tag, input logic r1,
                   input logic [31:0] s1, input logic r2, input logic [31:0] s2);
    cur.dv = 1'b1; cur.op = op; cur.tag = tag;
    cur.r1 = r1; cur.s1 = s1; cur.r2 = r2; cur.s2 = s2;
  endtask

  task automatic c0(input logic [5:0] t, input logic [31:0] dt);
    cur.c0v = 1'b1; cur.c0t = t; cur.c0d = dt;
  endtask

  task automatic c1(input logic [5:0] t, input logic [31:0] dt);
    cur.c1v = 1'b1; cur.c1t = t; cur.c1d = dt;
  endtask

  task automatic is(input logic sel);
    cur.iv = 1'b1; cur.isel = sel;
  endtask

  task automatic ei(input logic [3:0] op, input logic [5:0] tag,
                    input logic [31:0] s1, input logic [31:0] s2);
    cur.e_chk = 1'b1; cur.e_op = op; cur.e_tag = tag; cur.e_s1 = s1; cur.e_s2 = s2;
  endtask

  task automatic e(input logic dr, input logic [1:0] rv);
    cur.e_dr = dr; cur.e_rv = rv;
    vq.push_back(cur);
  endtask

  task automatic drive(input vec_t v);
    bus.i_disp_vld      = v.dv;
    bus.i_disp_op       = v.op;
    bus.i_disp_rob_tag  = v.tag;
    bus.i_disp_src1_rdy = v.r1;
    bus.i_disp_src1     = v.s1;
    bus.i_disp_src2_rdy = v.r2;
    bus.i_disp_src2     = v.s2;
    bus.i_cdb0_vld      = v.c0v;
    bus.i_cdb0_tag      = v.c0t;
    bus.i_cdb0_data     = v.c0d;
    bus.i_cdb1_vld      = v.c1v;
    bus.i_cdb1_tag      = v.c1t;
    bus.i_cdb1_data     = v.c1d;
    bus.i_issue_vld     = v.iv;
    bus.i_issue_sel     = v.isel;
    bus.i_flush         = v.fl;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    nv();
    drive(cur);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset disp_rdy", {31'd0, bus.o_disp_rdy}, 32'd1);
    chk("reset rdy_vec", {30'd0, bus.o_rdy_vec}, 32'd0);
    step();

    // basic dispatch and issue
    nv(); d(4'h3, 6'd1, 1'b1, 32'h11, 1'b1, 32'h22);           e(1'b1, 2'b00);
    nv(); is(1'b0); ei(4'h3, 6'd1, 32'h11, 32'h22);             e(1'b1, 2'b01);
    nv();                                                       e(1'b1, 2'b00);
    // wakeup of a stored source from cdb0
    nv(); d(4'h5, 6'd2, 1'b0, 32'h5, 1'b1, 32'h33);             e(1'b1, 2'b00);
    nv(); c0(6'd5, 32'hABCD); c1(6'd7, 32'hDEAD);               e(1'b1, 2'b00);
    nv(); is(1'b0); ei(4'h5, 6'd2, 32'hABCD, 32'h33);           e(1'b1, 2'b01);
    nv();                                                       e(1'b1, 2'b00);
    // capture from cdb1 during dispatch
    nv(); d(4'h6, 6'd3, 1'b1, 32'h44, 1'b0, 32'h9); c1(6'd9, 32'h77); e(1'b1, 2'b00);
    nv(); is(1'b0); ei(4'h6, 6'd3, 32'h44, 32'h77);             e(1'b1, 2'b01);
    nv();                                                       e(1'b1, 2'b00);
    // full station, issue frees entry 1 for the next cycle only
    nv(); d(4'h1, 6'd10, 1'b1, 32'h100, 1'b1, 32'h200);         e(1'b1, 2'b00);
    nv(); d(4'h2, 6'd11, 1'b1, 32'h300, 1'b1, 32'h400);         e(1'b1, 2'b01);
    nv(); d(4'h4, 6'd12, 1'b1, 32'h500, 1'b1, 32'h600); is(1'b1);
          ei(4'h2, 6'd11, 32'h300, 32'h400);                    e(1'b0, 2'b11);
    nv(); d(4'h4, 6'd12, 1'b1, 32'h500, 1'b1, 32'h600);         e(1'b1, 2'b01);
    nv(); is(1'b1); ei(4'h4, 6'd12, 32'h500, 32'h600);          e(1'b0, 2'b11);
    // flush with both entries busy and with a free entry
    nv(); d(4'h7, 6'd13, 1'b0, 32'd20, 1'b1, 32'h1);            e(1'b1, 2'b01);
    nv(); d(4'h8, 6'd14, 1'b1, 32'h9, 1'b1, 32'hA); cur.fl = 1'b1; e(1'b0, 2'b01);
    nv(); d(4'h8, 6'd14, 1'b1, 32'hD, 1'b1, 32'hE); cur.fl = 1'b1; e(1'b1, 2'b00);
    nv(); d(4'h9, 6'd15, 1'b1, 32'hB, 1'b1, 32'hC);             e(1'b1, 2'b00);
    nv(); is(1'b0); ei(4'h9, 6'd15, 32'hB, 32'hC);              e(1'b1, 2'b01);
    // dispatch, wakeup and issue overlapping in the same cycles
    nv(); d(4'hA, 6'd16, 1'b0, 32'd21, 1'b1, 32'h2);            e(1'b1, 2'b00);
    nv(); d(4'hB, 6'd17, 1'b1, 32'h3, 1'b0, 32'd22); c0(6'd21, 32'h55); e(1'b1, 2'b00);
    nv(); is(1'b0); c1(6'd22, 32'h66); ei(4'hA, 6'd16, 32'h55, 32'h2); e(1'b0, 2'b01);
    nv(); d(4'hC, 6'd19, 1'b1, 32'h8, 1'b1, 32'h9); is(1'b1);
          ei(4'hB, 6'd17, 32'h3, 32'h66);                       e(1'b1, 2'b10);
    nv(); is(1'b0); ei(4'hC, 6'd19, 32'h8, 32'h9);              e(1'b1, 2'b01);
    nv();                                                       e(1'b1, 2'b00);

    for (int k = 0; k < vq.size(); k++) begin
      drive(vq[k]);
      @(negedge clk);
      chk($sformatf("row%0d disp_rdy", k), {31'd0, bus.o_disp_rdy}, {31'd0, vq[k].e_dr});
      chk($sformatf("row%0d rdy_vec", k), {30'd0, bus.o_rdy_vec}, {30'd0, vq[k].e_rv});
      if (vq[k].e_chk) begin
        chk($sformatf("row%0d issue_op", k), {28'd0, bus.o_issue_op}, {28'd0, vq[k].e_op});
        chk($sformatf("row%0d issue_tag", k), {26'd0, bus.o_issue_rob_tag}, {26'd0, vq[k].e_tag});
        chk($sformatf("row%0d issue_src1", k), bus.o_issue_src1, vq[k].e_s1);
        chk($sformatf("row%0d issue_src2", k), bus.o_issue_src2, vq[k].e_s2);
      end
      step();
    end

    // reset in the middle of operation empties the station like a flush
    nv(); d(4'h1, 6'd30, 1'b1, 32'h1, 1'b1, 32'h2); drive(cur);
    step();
    step();
    nv(); drive(cur);
    @(negedge clk);
    chk("pre-reset rdy_vec", {30'd0, bus.o_rdy_vec}, 32'd3);
    chk("pre-reset disp_rdy", {31'd0, bus.o_disp_rdy}, 32'd0);
    step();
    rst_n = 1'b0;
    nv(); d(4'h2, 6'd31, 1'b1, 32'h3, 1'b1, 32'h4); drive(cur);
    step();
    rst_n = 1'b1;
    nv(); drive(cur);
    @(negedge clk);
    chk("mid-reset rdy_vec", {30'd0, bus.o_rdy_vec}, 32'd0);
    chk("mid-reset disp_rdy", {31'd0, bus.o_disp_rdy}, 32'd1);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
